// File: rtl/hex_disp_pkg.sv
// -----------------------------------------------------------------------------
// hex_disp_pkg
// Shared definitions for the multiplexed hex LED display controller:
//   - scan FSM state encoding (BLANK / DRIVE)
//   - SEG_BLANK, the all-segments-off pattern (active-low)
//   - hex_to_seg(): hex nibble to active-low {g,f,e,d,c,b,a} decode
//   - cnt_width(): width of the shared scan down-counter
// -----------------------------------------------------------------------------
package hex_disp_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Counter must hold max(SCAN_DIV, BLANK_CYC) - 1; never narrower than 1 bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        if (m < 2) begin
            return 1;
        end else begin
            return $clog2(m);
        end
    endfunction

    // Active-low 7-segment decode, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h18;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            4'hF:    s = 7'h0E;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/hex_display_ctrl_scan_timer.sv
// -----------------------------------------------------------------------------
// scan_timer
// Reloadable down-counter shared by both scan states, plus the digit index
// with wrap from NUM_DIGITS-1 back to 0.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   reload       : load reload_val into the counter this edge (state change)
//   reload_val   : value to load (duration of the next state minus one)
//   idx_inc      : advance the digit index this edge
//   tc           : terminal count, high while the counter is zero
//   idx          : current digit index
// -----------------------------------------------------------------------------
module scan_timer #(
    parameter int NUM_DIGITS = 8,
    parameter int CNT_W      = 16,
    parameter int IDX_W      = 3,
    parameter int RESET_VAL  = 499
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             reload,
    input  logic [CNT_W-1:0] reload_val,
    input  logic             idx_inc,
    output logic             tc,
    output logic [IDX_W-1:0] idx
);

    logic [CNT_W-1:0] cnt_r;
    logic [IDX_W-1:0] idx_r;

    // Down-counter: reload on state change, otherwise count to zero and hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= CNT_W'(RESET_VAL);
        end else if (reload) begin
            cnt_r <= reload_val;
        end else if (cnt_r != {CNT_W{1'b0}}) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Digit index with wrap at the last digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r <= {IDX_W{1'b0}};
        end else if (idx_inc) begin
            if (idx_r == IDX_W'(NUM_DIGITS - 1)) begin
                idx_r <= {IDX_W{1'b0}};
            end else begin
                idx_r <= idx_r + IDX_W'(1);
            end
        end else begin
            idx_r <= idx_r;
        end
    end

    assign tc  = (cnt_r == {CNT_W{1'b0}});
    assign idx = idx_r;

endmodule

// File: rtl/hex_display_ctrl.sv
// -----------------------------------------------------------------------------
// hex_display_ctrl
// Scanning controller for a multiplexed common-anode hex LED display.
// Bytes from the UART RX path are shifted into a NUM_DIGITS-nibble buffer;
// one shared decoder is time-multiplexed across the digits, with an all-off
// blank interval between digit drive periods to prevent ghosting.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   rx_data    : received byte
//   rx_valid   : rx_data valid
//   rx_ready   : byte accepted this cycle (low while clear or in reset)
//   clear      : synchronous buffer clear, level-sensitive
//   seg        : segments {g,f,e,d,c,b,a}, active-low, registered
//   dig_en     : digit enables, active-low, at most one low, registered
// Build option:
//   HEX_LZ_BLANK_EN : when defined, digits above the most significant nonzero
//                     nibble are blanked (digit 0 is always shown).
// -----------------------------------------------------------------------------
module hex_display_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 50000,
    parameter int BLANK_CYC  = 500
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    input  logic                  clear,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] dig_en
);

    import hex_disp_pkg::*;

    localparam int BUF_W = NUM_DIGITS * 4;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = cnt_width(SCAN_DIV, BLANK_CYC);

    logic [BUF_W-1:0]      buffer_r;
    scan_state_t           state_r;
    scan_state_t           state_nxt_s;
    logic                  reload_s;
    logic [CNT_W-1:0]      reload_val_s;
    logic                  idx_inc_s;
    logic                  tc_s;
    logic [IDX_W-1:0]      idx_s;
    logic [3:0]            nib_s;
    logic                  show_s;
    logic [6:0]            seg_r;
    logic [NUM_DIGITS-1:0] dig_en_r;

    // rx_ready is forced low while reset is asserted.
    assign rx_ready = rst_n & ~clear;

    // Nibble buffer: clear wins over a handshake; a byte shifts in at the bottom.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buffer_r <= {BUF_W{1'b0}};
        end else if (clear) begin
            buffer_r <= {BUF_W{1'b0}};
        end else if (rx_valid && rx_ready) begin
            buffer_r <= (buffer_r << 8) | BUF_W'(rx_data);
        end else begin
            buffer_r <= buffer_r;
        end
    end

    scan_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .CNT_W      (CNT_W),
        .IDX_W      (IDX_W),
        .RESET_VAL  (BLANK_CYC - 1)
    ) u_scan_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .reload     (reload_s),
        .reload_val (reload_val_s),
        .idx_inc    (idx_inc_s),
        .tc         (tc_s),
        .idx        (idx_s)
    );

    // Scan FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_BLANK;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Scan FSM next state; the counter reloads with the new state's length.
    always_comb begin
        state_nxt_s  = state_r;
        reload_s     = 1'b0;
        reload_val_s = {CNT_W{1'b0}};
        idx_inc_s    = 1'b0;
        case (state_r)
            ST_BLANK: begin
                if (tc_s) begin
                    state_nxt_s  = ST_DRIVE;
                    reload_s     = 1'b1;
                    reload_val_s = CNT_W'(SCAN_DIV - 1);
                end else begin
                    state_nxt_s  = ST_BLANK;
                end
            end
            ST_DRIVE: begin
                if (tc_s) begin
                    state_nxt_s  = ST_BLANK;
                    reload_s     = 1'b1;
                    reload_val_s = CNT_W'(BLANK_CYC - 1);
                    idx_inc_s    = 1'b1;
                end else begin
                    state_nxt_s  = ST_DRIVE;
                end
            end
            default: begin
                state_nxt_s  = ST_BLANK;
                reload_s     = 1'b1;
                reload_val_s = CNT_W'(BLANK_CYC - 1);
            end
        endcase
    end

    assign nib_s = buffer_r[{idx_s, 2'b00} +: 4];

`ifdef HEX_LZ_BLANK_EN
    logic [IDX_W-1:0] msn_s;

    // Index of the most significant nonzero nibble (0 for an all-zero buffer).
    always_comb begin
        msn_s = {IDX_W{1'b0}};
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (buffer_r[i*4 +: 4] != 4'h0) begin
                msn_s = IDX_W'(i);
            end else begin
                msn_s = msn_s;
            end
        end
    end

    assign show_s = (idx_s <= msn_s);
`else
    assign show_s = 1'b1;
`endif

    // Registered pin drivers; they reflect state, index and buffer one cycle late.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_r    <= SEG_BLANK;
            dig_en_r <= {NUM_DIGITS{1'b1}};
        end else if (state_r == ST_DRIVE) begin
            seg_r    <= show_s ? hex_to_seg(nib_s) : SEG_BLANK;
            dig_en_r <= ~(NUM_DIGITS'(1) << idx_s);
        end else begin
            seg_r    <= SEG_BLANK;
            dig_en_r <= {NUM_DIGITS{1'b1}};
        end
    end

    assign seg    = seg_r;
    assign dig_en = dig_en_r;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hex_display_ctrl
// Directed scenarios followed by randomized traffic on a 4-digit instance.
// The reference model tracks the buffer as a plain integer and derives the
// scan position from the number of edges since reset release.
// -----------------------------------------------------------------------------
module tb_hex_display_ctrl;

    localparam int N = 4;
    localparam int S = 4;
    localparam int B = 2;
    localparam int P = S + B;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       clear;
    logic [6:0] seg;
    logic [N-1:0] dig_en;

    int errors;
    int checks;
    int k;
    logic [15:0] mbuf;

    logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    hex_display_ctrl #(
        .NUM_DIGITS (N),
        .SCAN_DIV   (S),
        .BLANK_CYC  (B)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .clear    (clear),
        .seg      (seg),
        .dig_en   (dig_en)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scan position after kk edges since release: each digit slot is B blank then S drive cycles.
    function automatic bit m_drive(input int kk);
        return (kk % P) >= B;
    endfunction

    function automatic int m_digit(input int kk);
        return (kk / P) % N;
    endfunction

    function automatic logic [6:0] m_seg(input int kk, input logic [15:0] b);
        int d;
        int top;
        logic [3:0] nib;
        if (!m_drive(kk)) return 7'h7F;
        d   = m_digit(kk);
        nib = 4'((b >> (4 * d)) & 16'h000F);
        top = 0;
        for (int i = 0; i < N; i++) begin
            if (((b >> (4 * i)) & 16'h000F) != 16'h0000) top = i;
        end
`ifdef HEX_LZ_BLANK_EN
        if (d > top) return 7'h7F;
`endif
        return dec_tab[nib];
    endfunction

    function automatic logic [N-1:0] m_dig(input int kk);
        if (!m_drive(kk)) return 4'hF;
        return 4'(~(32'd1 << m_digit(kk)));
    endfunction

    // One clock cycle; starts and ends at a falling edge.
    task automatic step(input logic v, input logic [7:0] d, input logic c);
        logic [6:0]   e_seg;
        logic [N-1:0] e_dig;
        rx_valid = v;
        rx_data  = d;
        clear    = c;
        #1;
        chk("rx_ready", 32'(rx_ready), 32'(!c));
        @(posedge clk);
        e_seg = m_seg(k, mbuf);
        e_dig = m_dig(k);
        if (c) mbuf = 16'h0000;
        else if (v) mbuf = {mbuf[7:0], d};
        k++;
        #1;
        chk("seg", 32'(seg), 32'(e_seg));
        chk("dig_en", 32'(dig_en), 32'(e_dig));
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    // Asynchronous reset between edges; outputs must drop immediately.
    task automatic do_reset();
        rx_valid = 1'b0;
        clear    = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dig_en", 32'(dig_en), 32'hF);
        chk("rst_rx_ready", 32'(rx_ready), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mbuf  = 16'h0000;
        k     = 0;
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        k        = 0;
        mbuf     = 16'h0000;
        rst_n    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        clear    = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("init_seg", 32'(seg), 32'h7F);
        chk("init_dig_en", 32'(dig_en), 32'hF);
        chk("init_rx_ready", 32'(rx_ready), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Two bytes -> 16'h12AB, watched for two full frames.
        step(1'b1, 8'h12, 1'b0);
        step(1'b1, 8'hAB, 1'b0);
        idle(2 * N * P);

        // Three bytes: oldest falls off.
        step(1'b1, 8'h01, 1'b0);
        step(1'b1, 8'h02, 1'b0);
        step(1'b1, 8'h03, 1'b0);
        idle(N * P);

        // Clear blocks the byte, then the byte is accepted.
        step(1'b1, 8'hFF, 1'b1);
        step(1'b1, 8'hFF, 1'b0);
        idle(N * P);

        // Byte load during digit 0 drive.
        for (int i = 0; i < 4 * N * P; i++) begin
            if (k > 0 && m_drive(k - 1) && m_digit(k - 1) == 0 && ((k - 1) % P) == B + 1) break;
            step(1'b0, 8'h00, 1'b0);
        end
        step(1'b1, 8'h5A, 1'b0);
        idle(P);

        // Reset in the middle of a drive period, then restart timing.
        for (int i = 0; i < 2 * P; i++) begin
            if (k > 0 && m_drive(k - 1) && ((k - 1) % P) == B + 1) break;
            step(1'b0, 8'h00, 1'b0);
        end
        do_reset();
        idle(N * P);

        // Leading-zero cases: 16'h0050 and all-zero.
        step(1'b1, 8'h00, 1'b0);
        step(1'b1, 8'h50, 1'b0);
        idle(N * P);
        step(1'b0, 8'h00, 1'b1);
        idle(N * P);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                step(($urandom_range(0, 3) == 0), 8'($urandom), ($urandom_range(0, 15) == 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
